mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_if.sv | 55 +++++
 rtl/mem_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the instruction/data caches, the arbiter and the memory port.
// The master modport is the arbiter's view; slave is the environment around it.
interface mem_bus_arbiter_if;
    localparam int unsigned CMD_W  = 2;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned CNT_W  = 5;

    // cache request side
    logic [CMD_W-1:0]  icache_command;
    logic [ADDR_W-1:0] icache_addr;
    logic [CMD_W-1:0]  dcache_command;
    logic [ADDR_W-1:0] dcache_addr;
    logic [DATA_W-1:0] dcache_data;

    // memory request/response side
    logic [CMD_W-1:0]  proc2mem_command;
    logic [ADDR_W-1:0] proc2mem_addr;
    logic [DATA_W-1:0] proc2mem_data;
    logic [TAG_W-1:0]  mem2proc_response;
    logic [DATA_W-1:0] mem2proc_data;
    logic [TAG_W-1:0]  mem2proc_tag;

    // per-cache return side
    logic [TAG_W-1:0]  Imem2proc_response;
    logic [TAG_W-1:0]  Imem2proc_tag;
    logic [DATA_W-1:0] Imem2proc_data;
    logic [TAG_W-1:0]  Dmem2proc_response;
    logic [TAG_W-1:0]  Dmem2proc_tag;
    logic [DATA_W-1:0] Dmem2proc_data;

    logic [CNT_W-1:0]  outstanding_count;
    logic              orphan_tag_err;

    modport master (
        input  icache_command, icache_addr,
        input  dcache_command, dcache_addr, dcache_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output Imem2proc_response, Imem2proc_tag, Imem2proc_data,
        output Dmem2proc_response, Dmem2proc_tag, Dmem2proc_data,
        output outstanding_count, orphan_tag_err
    );

    modport slave (
        output icache_command, icache_addr,
        output dcache_command, dcache_addr, dcache_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  Imem2proc_response, Imem2proc_tag, Imem2proc_data,
        input  Dmem2proc_response, Dmem2proc_tag, Dmem2proc_data,
        input  outstanding_count, orphan_tag_err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-cache memory port arbiter: dcache priority with icache anti-starvation,
// plus a tag owner table that routes returning load data back to the requester.
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic               clock,
    input logic               reset,
    mem_bus_arbiter_if.master bus
);
    localparam int unsigned CMD_W    = 2;
    localparam int unsigned ADDR_W   = 64;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned TAG_W    = 4;
    localparam int unsigned N_TAGS   = 16;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    localparam logic [CMD_W-1:0] BUS_NONE = 2'd0;
    localparam logic [CMD_W-1:0] BUS_LOAD = 2'd1;
    localparam logic             OWNER_I  = 1'b0;
    localparam logic             OWNER_D  = 1'b1;

    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_cnt_next;
    logic [N_TAGS-1:0]   entry_valid;
    logic [N_TAGS-1:0]   entry_owner;
    logic [N_TAGS-1:0]   entry_valid_next;
    logic [N_TAGS-1:0]   entry_owner_next;
    logic [N_TAGS-1:0]   valid_after_retire;
    logic [CNT_W-1:0]    live_count;
    logic [CNT_W-1:0]    live_count_next;

    logic i_valid;
    logic d_valid;
    logic starved;
    logic grant_i;
    logic grant_d;
    logic alloc;
    logic alloc_owner;
    logic alloc_new;
    logic tag_present;
    logic ret_hit;
    logic ret_orphan;
    logic ret_owner;

    // Arbitration: reset masks both requesters so nothing reaches memory.
    always_comb begin
        i_valid = !reset && (bus.icache_command != BUS_NONE);
        d_valid = !reset && (bus.dcache_command != BUS_NONE);
        starved = (starve_cnt == STARVE_W'(STARVE_LIMIT));
        grant_i = i_valid && (!d_valid || starved);
        grant_d = d_valid && !grant_i;
    end

    // Winner drives the memory port combinationally; icache never carries data.
    always_comb begin
        bus.proc2mem_command = BUS_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        if (grant_d) begin
            bus.proc2mem_command = bus.dcache_command;
            bus.proc2mem_addr    = bus.dcache_addr;
            bus.proc2mem_data    = bus.dcache_data;
        end else if (grant_i) begin
            bus.proc2mem_command = bus.icache_command;
            bus.proc2mem_addr    = bus.icache_addr;
        end
    end

    // Starvation counter counts consecutive dcache wins over a waiting icache.
    always_comb begin
        starve_cnt_next = starve_cnt;
        if (grant_d && i_valid) begin
            if (!starved) begin
                starve_cnt_next = starve_cnt + STARVE_W'(1);
            end
        end else if (grant_i || !i_valid) begin
            starve_cnt_next = '0;
        end
    end

    // Accept tag goes only to the winner; stores never occupy a tag.
    always_comb begin
        bus.Imem2proc_response = grant_i ? bus.mem2proc_response : '0;
        bus.Dmem2proc_response = grant_d ? bus.mem2proc_response : '0;
        alloc = (bus.mem2proc_response != '0) &&
                ((grant_i && (bus.icache_command == BUS_LOAD)) ||
                 (grant_d && (bus.dcache_command == BUS_LOAD)));
        alloc_owner = grant_d ? OWNER_D : OWNER_I;
    end

    // Returning tags are routed with the pre-update table, so a same-cycle
    // reallocation of that tag still sends this return to the old owner.
    always_comb begin
        tag_present = !reset && (bus.mem2proc_tag != '0);
        ret_hit     = tag_present && entry_valid[bus.mem2proc_tag];
        ret_orphan  = tag_present && !entry_valid[bus.mem2proc_tag];
        ret_owner   = entry_owner[bus.mem2proc_tag];
        bus.Imem2proc_tag  = (ret_hit && (ret_owner == OWNER_I)) ? bus.mem2proc_tag : '0;
        bus.Dmem2proc_tag  = (ret_hit && (ret_owner == OWNER_D)) ? bus.mem2proc_tag : '0;
        bus.Imem2proc_data = bus.mem2proc_data;
        bus.Dmem2proc_data = bus.mem2proc_data;
        bus.orphan_tag_err = ret_orphan;
    end

    // Table update: retire first, then allocate, so a reused tag ends valid.
    always_comb begin
        valid_after_retire = entry_valid;
        if (ret_hit) begin
            valid_after_retire[bus.mem2proc_tag] = 1'b0;
        end
        entry_valid_next = valid_after_retire;
        entry_owner_next = entry_owner;
        alloc_new        = 1'b0;
        if (alloc) begin
            alloc_new = !valid_after_retire[bus.mem2proc_response];
            entry_valid_next[bus.mem2proc_response] = 1'b1;
            entry_owner_next[bus.mem2proc_response] = alloc_owner;
        end
        live_count_next = live_count + CNT_W'(alloc_new) - CNT_W'(ret_hit);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt  <= '0;
            entry_valid <= '0;
            entry_owner <= '0;
            live_count  <= '0;
        end else begin
            starve_cnt  <= starve_cnt_next;
            entry_valid <= entry_valid_next;
            entry_owner <= entry_owner_next;
            live_count  <= live_count_next;
        end
    end

    assign bus.outstanding_count = live_count;

    // Widths of the data path must line up with the bus bundle.
    if (ADDR_W != 64 || DATA_W != 64) begin : g_width_guard
        $error("mem_bus_arbiter: address/data width must be 64");
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a rule-level model checked every cycle
// plus hand-computed expectations for the key scenarios.
module tb_mem_bus_arbiter;
    localparam int unsigned LIMIT = 4;

    logic clock;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: which tags are live and who owns them, plus consecutive dcache wins.
    bit m_valid [16];
    bit m_is_d  [16];
    int m_starve   = 0;
    int m_last_win = 0;   // 0 none, 1 icache, 2 dcache

    always @(negedge clock) begin : compare
        logic        iv, dv;
        int          win, live;
        logic [1:0]  e_cmd;
        logic [63:0] e_addr, e_data;
        logic [3:0]  e_ir, e_dr, e_it, e_dt, rs, tg;
        logic        e_orph;

        live = 0;
        for (int k = 0; k < 16; k++) if (m_valid[k]) live++;
        rs = bus.mem2proc_response;
        tg = bus.mem2proc_tag;
        e_cmd = 2'd0; e_addr = '0; e_data = '0;
        e_ir = '0; e_dr = '0; e_it = '0; e_dt = '0; e_orph = 1'b0;
        win = 0;
        if (reset) begin
            for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
            m_starve = 0;
        end else begin
            iv = bus.icache_command != 2'd0;
            dv = bus.dcache_command != 2'd0;
            if (iv && dv) win = (m_starve >= int'(LIMIT)) ? 1 : 2;
            else if (iv)  win = 1;
            else if (dv)  win = 2;
            if (win == 1) begin
                e_cmd = bus.icache_command; e_addr = bus.icache_addr; e_ir = rs;
            end else if (win == 2) begin
                e_cmd = bus.dcache_command; e_addr = bus.dcache_addr;
                e_data = bus.dcache_data; e_dr = rs;
            end
            if (tg != 0) begin
                if (m_valid[tg]) begin
                    if (m_is_d[tg]) e_dt = tg; else e_it = tg;
                    m_valid[tg] = 1'b0;
                end else begin
                    e_orph = 1'b1;
                end
            end
            if (win != 0 && e_cmd == 2'd1 && rs != 0) begin
                m_valid[rs] = 1'b1;
                m_is_d[rs]  = (win == 2);
            end
            if (win == 2 && iv) m_starve = (m_starve + 1 > int'(LIMIT)) ? int'(LIMIT) : m_starve + 1;
            else                m_starve = 0;
        end
        m_last_win = win;
        check("proc2mem_command",   64'(bus.proc2mem_command),   64'(e_cmd));
        check("proc2mem_addr",      bus.proc2mem_addr,           e_addr);
        check("proc2mem_data",      bus.proc2mem_data,           e_data);
        check("Imem2proc_response", 64'(bus.Imem2proc_response), 64'(e_ir));
        check("Dmem2proc_response", 64'(bus.Dmem2proc_response), 64'(e_dr));
        check("Imem2proc_tag",      64'(bus.Imem2proc_tag),      64'(e_it));
        check("Dmem2proc_tag",      64'(bus.Dmem2proc_tag),      64'(e_dt));
        check("Imem2proc_data",     bus.Imem2proc_data,          bus.mem2proc_data);
        check("Dmem2proc_data",     bus.Dmem2proc_data,          bus.mem2proc_data);
        check("orphan_tag_err",     64'(bus.orphan_tag_err),     64'(e_orph));
        check("outstanding_count",  64'(bus.outstanding_count),  64'(live));
    end

    task automatic idle();
        bus.icache_command = 2'd0; bus.icache_addr = '0;
        bus.dcache_command = 2'd0; bus.dcache_addr = '0; bus.dcache_data = '0;
        bus.mem2proc_response = '0; bus.mem2proc_tag = '0;
    endtask

    // Advance to just after the next rising edge; fresh return data every cycle.
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        bus.mem2proc_data = {32'hD47A_0000, 32'(cyc)};
    endtask

    task automatic mid();
        @(negedge clock);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [9:0] dut_seq, mdl_seq;
        reset = 1'b1;
        bus.mem2proc_data = '0;
        // Requests and returns present during reset must be ignored.
        bus.icache_command = 2'd1; bus.icache_addr = 64'h1111;
        bus.dcache_command = 2'd2; bus.dcache_addr = 64'h2222; bus.dcache_data = 64'h3333;
        bus.mem2proc_response = 4'd5; bus.mem2proc_tag = 4'd3;
        tick(); tick();
        mid();
        check("reset proc2mem_command", 64'(bus.proc2mem_command), 64'd0);
        check("reset Dmem2proc_response", 64'(bus.Dmem2proc_response), 64'd0);
        check("reset Imem2proc_tag", 64'(bus.Imem2proc_tag), 64'd0);
        check("reset orphan_tag_err", 64'(bus.orphan_tag_err), 64'd0);
        check("reset outstanding_count", 64'(bus.outstanding_count), 64'd0);
        tick();
        reset = 1'b0;
        idle();
        tick();

        // icache load accepted with tag 3, returned ten cycles later
        bus.icache_command = 2'd1; bus.icache_addr = 64'h1000; bus.mem2proc_response = 4'd3;
        mid();
        check("i load proc2mem_addr", bus.proc2mem_addr, 64'h1000);
        check("i load Imem2proc_response", 64'(bus.Imem2proc_response), 64'd3);
        check("i load Dmem2proc_response", 64'(bus.Dmem2proc_response), 64'd0);
        tick(); idle();
        mid();
        check("i load count after accept", 64'(bus.outstanding_count), 64'd1);
        repeat (9) tick();
        bus.mem2proc_tag = 4'd3;
        mid();
        check("i return Imem2proc_tag", 64'(bus.Imem2proc_tag), 64'd3);
        check("i return Dmem2proc_tag", 64'(bus.Dmem2proc_tag), 64'd0);
        tick(); idle();
        mid();
        check("i return count after retire", 64'(bus.outstanding_count), 64'd0);

        // dcache store: accepted but never allocates, so its tag returns as orphan
        tick();
        bus.dcache_command = 2'd2; bus.dcache_addr = 64'h2000;
        bus.dcache_data = 64'hDEAD_BEEF_0000_0005; bus.mem2proc_response = 4'd5;
        mid();
        check("store proc2mem_command", 64'(bus.proc2mem_command), 64'd2);
        check("store proc2mem_data", bus.proc2mem_data, 64'hDEAD_BEEF_0000_0005);
        check("store Dmem2proc_response", 64'(bus.Dmem2proc_response), 64'd5);
        tick(); idle();
        mid();
        check("store count", 64'(bus.outstanding_count), 64'd0);
        tick();
        bus.mem2proc_tag = 4'd5;
        mid();
        check("store tag orphan_tag_err", 64'(bus.orphan_tag_err), 64'd1);
        check("store tag Dmem2proc_tag", 64'(bus.Dmem2proc_tag), 64'd0);
        check("store tag Imem2proc_tag", 64'(bus.Imem2proc_tag), 64'd0);
        tick(); idle();

        // Both caches load continuously, memory rejects everything (1 = icache win)
        dut_seq = '0; mdl_seq = '0;
        bus.icache_command = 2'd1; bus.icache_addr = 64'hA000;
        bus.dcache_command = 2'd1; bus.dcache_addr = 64'hB000;
        for (int i = 0; i < 10; i++) begin
            mid();
            dut_seq = {dut_seq[8:0], bus.proc2mem_addr == 64'hA000};
            mdl_seq = {mdl_seq[8:0], m_last_win == 1};
            tests++;
            if (bus.Imem2proc_response != 0 || bus.Dmem2proc_response != 0) begin
                fails++;
                $display("FAIL reject responses: got I=%0d D=%0d expected 0/0",
                         bus.Imem2proc_response, bus.Dmem2proc_response);
            end
            tick();
        end
        idle();
        check("grant sequence DDDDIDDDDI", 64'(dut_seq), 64'(10'b0000100001));
        check("model grant sequence", 64'(mdl_seq), 64'(10'b0000100001));
        mid();
        check("reject count", 64'(bus.outstanding_count), 64'd0);

        // Tag 7 retires from icache while dcache is granted tag 7 in the same cycle
        tick();
        bus.icache_command = 2'd1; bus.icache_addr = 64'h3000; bus.mem2proc_response = 4'd7;
        tick(); idle();
        bus.dcache_command = 2'd1; bus.dcache_addr = 64'h4000;
        bus.mem2proc_response = 4'd7; bus.mem2proc_tag = 4'd7;
        mid();
        check("reuse Imem2proc_tag", 64'(bus.Imem2proc_tag), 64'd7);
        check("reuse Dmem2proc_tag", 64'(bus.Dmem2proc_tag), 64'd0);
        check("reuse Dmem2proc_response", 64'(bus.Dmem2proc_response), 64'd7);
        check("reuse count before", 64'(bus.outstanding_count), 64'd1);
        tick(); idle();
        mid();
        check("reuse count after", 64'(bus.outstanding_count), 64'd1);
        tick();
        bus.mem2proc_tag = 4'd7;
        mid();
        check("reuse new owner Dmem2proc_tag", 64'(bus.Dmem2proc_tag), 64'd7);
        check("reuse new owner Imem2proc_tag", 64'(bus.Imem2proc_tag), 64'd0);
        tick(); idle();

        // Fill all 15 tags, then reset discards them
        for (int t = 1; t <= 15; t++) begin
            idle();
            if (t % 2 == 1) begin
                bus.icache_command = 2'd1; bus.icache_addr = 64'(t * 256);
            end else begin
                bus.dcache_command = 2'd1; bus.dcache_addr = 64'(t * 256);
            end
            bus.mem2proc_response = 4'(t);
            tick();
        end
        idle();
        mid();
        check("fill count 15", 64'(bus.outstanding_count), 64'd15);
        tick();
        reset = 1'b1;
        bus.dcache_command = 2'd1; bus.mem2proc_response = 4'd9; bus.mem2proc_tag = 4'd4;
        mid();
        check("reset pulse proc2mem_command", 64'(bus.proc2mem_command), 64'd0);
        check("reset pulse Dmem2proc_response", 64'(bus.Dmem2proc_response), 64'd0);
        check("reset pulse Dmem2proc_tag", 64'(bus.Dmem2proc_tag), 64'd0);
        tick();
        reset = 1'b0;
        idle();
        mid();
        check("after reset count", 64'(bus.outstanding_count), 64'd0);
        tick();
        bus.mem2proc_tag = 4'd2;
        mid();
        check("discarded tag orphan_tag_err", 64'(bus.orphan_tag_err), 64'd1);
        check("discarded tag Dmem2proc_tag", 64'(bus.Dmem2proc_tag), 64'd0);
        check("discarded tag Imem2proc_tag", 64'(bus.Imem2proc_tag), 64'd0);
        tick(); idle();
        mid();
        check("orphan is one cycle", 64'(bus.orphan_tag_err), 64'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
